// File: rtl/kan_pkg.sv
`default_nettype none
// ============================================================================
//  Package  : kan_pkg
//  Purpose  : Values shared by the KAN MNIST classifier, its input-side frame
//             loader and their benches. Holds the frame geometry, the class
//             count and the loader state encoding.
//  Contents : KAN_NUM_PIXELS  pixels per 28x28 frame
//             KAN_PIX_W       bits per pixel
//             KAN_CNT_W       pixel-counter width (2**KAN_CNT_W > KAN_NUM_PIXELS)
//             KAN_NUM_CLASSES classifier output classes
//             ld_state_e      frame loader states
//  Revision : 1.0  initial release
// ============================================================================
package kan_pkg;

    localparam int KAN_NUM_PIXELS  = 784;
    localparam int KAN_PIX_W       = 8;
    localparam int KAN_CNT_W       = 10;
    localparam int KAN_NUM_CLASSES = 10;

    // Loader states. FILL collects pixels, FULL holds a finished frame for
    // the classifier, DISCARD swallows the tail of an over-long frame.
    typedef enum logic [1:0] {
        LD_FILL    = 2'd0,
        LD_FULL    = 2'd1,
        LD_DISCARD = 2'd2
    } ld_state_e;

endpackage : kan_pkg
`default_nettype wire

// File: rtl/kan_frame_loader.sv
`default_nettype none
// ============================================================================
//  Module   : kan_frame_loader
//  Purpose  : Input-side frame writer for the KAN MNIST classifier. Accepts a
//             raster-order pixel stream over valid/ready, writes it into a
//             flop-based frame buffer and, once a complete frame has arrived,
//             holds it on a parallel output array until acknowledged.
//             Too-short and too-long frames are rejected with an error pulse.
//  Ports    : clk          rising-edge clock
//             reset        asynchronous reset, active low
//             s_valid      upstream pixel valid
//             s_data       pixel value
//             s_last       final pixel of a frame
//             s_ready      loader accepts a pixel this cycle
//             frame_data   buffered frame, index 0 = top-left pixel
//             frame_valid  frame_data holds a complete, stable frame
//             frame_ack    consumer releases the frame
//             err_short    1-cycle pulse: s_last before the final pixel
//             err_long     1-cycle pulse: final pixel arrived without s_last
//             frame_count  completed frames, modulo 2**16
//  Revision : 1.0  initial release
// ============================================================================
module kan_frame_loader
    import kan_pkg::*;
#(
    parameter int NUM_PIXELS = KAN_NUM_PIXELS,
    parameter int PIX_W      = KAN_PIX_W,
    parameter int CNT_W      = KAN_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             s_valid,
    input  logic [PIX_W-1:0] s_data,
    input  logic             s_last,
    output logic             s_ready,
    output logic [PIX_W-1:0] frame_data [0:NUM_PIXELS-1],
    output logic             frame_valid,
    input  logic             frame_ack,
    output logic             err_short,
    output logic             err_long,
    output logic [15:0]      frame_count
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_PIXELS - 1);

    ld_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      frame_count_q, frame_count_d;
    logic             ready_q, ready_d;
    logic             valid_q, valid_d;
    logic             err_short_q, err_short_d;
    logic             err_long_q, err_long_d;

    logic             pix_accept;
    logic             at_last_idx;
    logic             wr_en;

    assign pix_accept  = s_valid && ready_q;
    assign at_last_idx = (cnt_q == LAST_IDX);

    // ------------------------------------------------------------------
    // State register and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= LD_FILL;
            cnt_q         <= '0;
            frame_count_q <= '0;
            ready_q       <= 1'b0;
            valid_q       <= 1'b0;
            err_short_q   <= 1'b0;
            err_long_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            frame_count_q <= frame_count_d;
            ready_q       <= ready_d;
            valid_q       <= valid_d;
            err_short_q   <= err_short_d;
            err_long_q    <= err_long_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        frame_count_d = frame_count_q;
        err_short_d   = 1'b0;
        err_long_d    = 1'b0;
        wr_en         = 1'b0;

        case (state_q)
            LD_FILL: begin
                if (pix_accept) begin
                    // The final slot is written even for an over-long frame;
                    // the frame is never presented, so the stale entry is
                    // simply overwritten by the next frame.
                    wr_en = 1'b1;
                    if (at_last_idx) begin
                        cnt_d = '0;
                        if (s_last) begin
                            state_d       = LD_FULL;
                            frame_count_d = frame_count_q + 16'd1;
                        end else begin
                            err_long_d = 1'b1;
                            state_d    = LD_DISCARD;
                        end
                    end else if (s_last) begin
                        err_short_d = 1'b1;
                        cnt_d       = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            LD_FULL: begin
                if (frame_ack) begin
                    state_d = LD_FILL;
                end
            end
            LD_DISCARD: begin
                if (pix_accept && s_last) begin
                    state_d = LD_FILL;
                end
            end
            default: begin
                state_d = LD_FILL;
                cnt_d   = '0;
            end
        endcase
    end

    // Handshake outputs follow the next state so that they are registered
    // yet aligned with the state they describe. Being held low through
    // reset, s_ready rises on the first edge after reset is released.
    always_comb begin
        ready_d = (state_d != LD_FULL);
        valid_d = (state_d == LD_FULL);
    end

    // ------------------------------------------------------------------
    // Frame buffer: one register per pixel, written by address decode of
    // the pixel counter, so the whole frame is visible in parallel.
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_PIXELS; gi++) begin : g_buf
        logic [PIX_W-1:0] pix_q;
        logic             sel;

        assign sel = wr_en && (cnt_q == CNT_W'(gi));

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                pix_q <= '0;
            end else if (sel) begin
                pix_q <= s_data;
            end
        end

        assign frame_data[gi] = pix_q;
    end

    assign s_ready     = ready_q;
    assign frame_valid = valid_q;
    assign err_short   = err_short_q;
    assign err_long    = err_long_q;
    assign frame_count = frame_count_q;

endmodule : kan_frame_loader
`default_nettype wire

// File: tb/tb_kan_frame_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_kan_frame_loader
//  Purpose  : Self-checking bench for kan_frame_loader. A behavioural model
//             tracks the expected outputs and buffer contents; a compare
//             process checks the DUT against it every cycle, and directed
//             scenarios add literal expectations.
//  Revision : 1.0  initial release
// ============================================================================
module tb_kan_frame_loader;
    import kan_pkg::*;

    localparam int N = KAN_NUM_PIXELS;
    localparam int W = KAN_PIX_W;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         s_valid = 1'b0;
    logic [W-1:0] s_data = '0;
    logic         s_last = 1'b0;
    logic         s_ready;
    logic [W-1:0] frame_data [0:N-1];
    logic         frame_valid;
    logic         frame_ack = 1'b0;
    logic         err_short;
    logic         err_long;
    logic [15:0]  frame_count;

    always #5 clk = ~clk;

    kan_frame_loader #(
        .NUM_PIXELS (N),
        .PIX_W      (W),
        .CNT_W      (KAN_CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .s_valid     (s_valid),
        .s_data      (s_data),
        .s_last      (s_last),
        .s_ready     (s_ready),
        .frame_data  (frame_data),
        .frame_valid (frame_valid),
        .frame_ack   (frame_ack),
        .err_short   (err_short),
        .err_long    (err_long),
        .frame_count (frame_count)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=timeout required=event", name);
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: pixels received in the current frame, whether an
    // over-long frame is being skipped, whether a finished frame is held.
    // ------------------------------------------------------------------
    bit          m_ready, m_held, m_skip, m_es, m_el, m_acc;
    int          m_got;
    logic [15:0] m_count;
    logic [W-1:0] m_buf [0:N-1];

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_ready = 0; m_held = 0; m_skip = 0; m_es = 0; m_el = 0;
            m_got = 0; m_count = 0;
            for (int i = 0; i < N; i++) m_buf[i] = '0;
        end else begin
            m_acc = s_valid && m_ready;
            m_es  = 0;
            m_el  = 0;
            if (m_held) begin
                if (frame_ack) m_held = 0;
            end else if (m_acc) begin
                if (m_skip) begin
                    if (s_last) m_skip = 0;
                end else begin
                    m_buf[m_got] = s_data;
                    m_got++;
                    if (m_got == N) begin
                        m_got = 0;
                        if (s_last) begin
                            m_held  = 1;
                            m_count = m_count + 16'd1;
                        end else begin
                            m_el   = 1;
                            m_skip = 1;
                        end
                    end else if (s_last) begin
                        m_es  = 1;
                        m_got = 0;
                    end
                end
            end
            m_ready = !m_held;
        end
    end

    // ------------------------------------------------------------------
    // Compare process, away from the active edge
    // ------------------------------------------------------------------
    int n_es = 0;
    int n_el = 0;
    int rot  = 0;

    always @(negedge clk) begin
        int bad;
        chk("s_ready",     {31'd0, s_ready},     {31'd0, m_ready});
        chk("frame_valid", {31'd0, frame_valid}, {31'd0, m_held});
        chk("err_short",   {31'd0, err_short},   {31'd0, m_es});
        chk("err_long",    {31'd0, err_long},    {31'd0, m_el});
        chk("frame_count", {16'd0, frame_count}, {16'd0, m_count});
        bad = -1;
        for (int i = 0; i < N; i++)
            if (bad < 0 && frame_data[i] !== m_buf[i]) bad = i;
        if (bad < 0) bad = rot;
        rot = (rot + 1) % N;
        chk($sformatf("frame_data[%0d]", bad), {24'd0, frame_data[bad]}, {24'd0, m_buf[bad]});
        if (err_short) n_es++;
        if (err_long)  n_el++;
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (inputs change 1 time unit after the rising edge)
    // ------------------------------------------------------------------
    bit ack_noise = 0;

    task automatic idle(input int n);
        s_valid = 1'b0;
        s_last  = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [W-1:0] d, input bit last, input bit gaps);
        int  t;
        bit  rdy;
        if (gaps && ($urandom % 2 == 0)) idle(1);
        s_valid   = 1'b1;
        s_data    = d;
        s_last    = last;
        frame_ack = ack_noise ? 1'($urandom % 2) : 1'b0;
        t = 0;
        forever begin
            @(negedge clk);
            rdy = s_ready;
            @(posedge clk);
            #1;
            if (rdy) break;
            t++;
            if (t > 50) begin
                timeout_fail("accept_timeout");
                break;
            end
        end
        s_valid   = 1'b0;
        s_last    = 1'b0;
        frame_ack = 1'b0;
    endtask

    task automatic wait_valid();
        int t = 0;
        while (!frame_valid && t < 40) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (!frame_valid) timeout_fail("frame_valid_timeout");
    endtask

    task automatic do_ack();
        frame_ack = 1'b1;
        @(posedge clk);
        #1;
        frame_ack = 1'b0;
    endtask

    task automatic send_random_frame(input bit gaps, output logic [W-1:0] first);
        logic [W-1:0] d;
        for (int i = 0; i < N; i++) begin
            d = W'($urandom);
            if (i == 0) first = d;
            send(d, i == N - 1, gaps);
        end
    endtask

    logic [W-1:0] sb [0:N-1];

    initial begin
        logic [W-1:0] v0;
        int es0, el0, bad;

        // Reset state
        #2 reset = 1'b0;
        #20;
        chk("rst_s_ready",     {31'd0, s_ready},     32'd0);
        chk("rst_frame_valid", {31'd0, frame_valid}, 32'd0);
        chk("rst_frame_count", {16'd0, frame_count}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        #1 chk("s_ready_after_release", {31'd0, s_ready}, 32'd0);

        // 1. Ramp frame
        for (int i = 0; i < N; i++) send(W'(i), i == N - 1, 1'b0);
        chk("t1_frame_valid", {31'd0, frame_valid}, 32'd1);
        chk("t1_fd5",         {24'd0, frame_data[5]}, 32'h05);
        chk("t1_fd783",       {24'd0, frame_data[783]}, 32'h0F);
        chk("t1_frame_count", {16'd0, frame_count}, 32'd1);
        chk("t1_s_ready",     {31'd0, s_ready}, 32'd0);

        // 2. Hold FULL with traffic present, then release
        for (int c = 0; c < 20; c++) begin
            s_valid = 1'b1;
            s_data  = W'($urandom);
            s_last  = 1'($urandom % 2);
            @(posedge clk);
            #1;
        end
        idle(0);
        chk("t2_s_ready_held", {31'd0, s_ready}, 32'd0);
        chk("t2_fd5_held",     {24'd0, frame_data[5]}, 32'h05);
        chk("t2_fd200_held",   {24'd0, frame_data[200]}, 32'hC8);
        do_ack();
        chk("t2_ack_valid", {31'd0, frame_valid}, 32'd0);
        chk("t2_ack_ready", {31'd0, s_ready}, 32'd1);
        for (int i = 0; i < N; i++) send(8'hAA, i == N - 1, 1'b0);
        chk("t2_frame_count", {16'd0, frame_count}, 32'd2);
        bad = 0;
        for (int i = 0; i < N; i++) if (frame_data[i] !== 8'hAA) bad = i;
        chk($sformatf("t2_all_AA[%0d]", bad), {24'd0, frame_data[bad]}, 32'hAA);
        do_ack();

        // 3. Short frame, then a good one
        es0 = n_es;
        for (int i = 0; i < 100; i++) send(W'($urandom), i == 99, 1'b0);
        idle(2);
        chk("t3_err_short_pulses", n_es - es0, 32'd1);
        chk("t3_no_valid", {31'd0, frame_valid}, 32'd0);
        send_random_frame(1'b0, v0);
        wait_valid();
        chk("t3_frame_count", {16'd0, frame_count}, 32'd3);
        do_ack();

        // 4. Long frame, tail dropped, then a good one
        es0 = n_es;
        el0 = n_el;
        for (int i = 0; i < N; i++) send(W'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) send(W'($urandom), i == 9, 1'b0);
        idle(2);
        chk("t4_err_long_pulses", n_el - el0, 32'd1);
        chk("t4_no_err_short", n_es - es0, 32'd0);
        chk("t4_no_valid", {31'd0, frame_valid}, 32'd0);
        send_random_frame(1'b0, v0);
        wait_valid();
        chk("t4_entry0", {24'd0, frame_data[0]}, {24'd0, v0});
        chk("t4_frame_count", {16'd0, frame_count}, 32'd4);
        do_ack();

        // 5. Random gaps and stray acks while filling, scoreboard compare
        for (int i = 0; i < N; i++) begin
            sb[i] = W'($urandom);
            ack_noise = (i < N - 50);
            send(sb[i], i == N - 1, 1'b1);
        end
        ack_noise = 0;
        wait_valid();
        bad = 0;
        for (int i = 0; i < N; i++) if (frame_data[i] !== sb[i]) bad = i;
        chk($sformatf("t5_scoreboard[%0d]", bad), {24'd0, frame_data[bad]}, {24'd0, sb[bad]});
        chk("t5_frame_count", {16'd0, frame_count}, 32'd5);
        do_ack();

        // 6. Asynchronous reset mid-frame and while holding a frame
        for (int i = 0; i < 400; i++) send(W'($urandom), 1'b0, 1'b0);
        #2 reset = 1'b0;
        #1;
        chk("t6a_frame_valid", {31'd0, frame_valid}, 32'd0);
        chk("t6a_s_ready",     {31'd0, s_ready}, 32'd0);
        chk("t6a_frame_count", {16'd0, frame_count}, 32'd0);
        chk("t6a_fd0",         {24'd0, frame_data[0]}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        send_random_frame(1'b0, v0);
        wait_valid();
        chk("t6b_frame_count", {16'd0, frame_count}, 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("t6c_frame_valid", {31'd0, frame_valid}, 32'd0);
        chk("t6c_s_ready",     {31'd0, s_ready}, 32'd0);
        chk("t6c_frame_count", {16'd0, frame_count}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        send_random_frame(1'b1, v0);
        wait_valid();
        chk("t6d_frame_count", {16'd0, frame_count}, 32'd1);
        chk("t6d_entry0", {24'd0, frame_data[0]}, {24'd0, v0});
        do_ack();
        idle(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_kan_frame_loader
`default_nettype wire
